// File: rtl/axis_bram_burst_adapter.sv
// rtl/axis_bram_burst_adapter.sv - AXI-Stream to wide BRAM line packer/unpacker with burst commands
//
// Packs WORDS_PER_LINE stream words into one BRAM line (write mode) or unpacks
// BRAM lines back into stream words (read mode). One start/done command moves
// cfg_lines consecutive lines starting at cfg_base. The address wraps modulo
// 2^ADDR_W.
//
// Ports:
//   aclk, areset            clock, synchronous active-high reset
//   cfg_start/mode/base/lines  command port (sampled in IDLE only)
//   busy, done, err_tlast   status: busy outside IDLE, done pulse, sticky framing error
//   s_axis_*                write-direction stream input
//   m_axis_*                read-direction stream output
//   bram_*                  single wide BRAM port, read latency RD_LAT

module axis_bram_burst_adapter #(
   parameter int DATA_W         = 32,
   parameter int WORDS_PER_LINE = 36,
   parameter int ADDR_W         = 12,
   parameter int RD_LAT         = 1,
   localparam int LINE_W        = DATA_W * WORDS_PER_LINE,
   localparam int PTR_W         = $clog2(WORDS_PER_LINE)
) (
   input  logic                aclk,
   input  logic                areset,

   input  logic                cfg_start,
   input  logic                cfg_mode,
   input  logic [ADDR_W-1:0]   cfg_base,
   input  logic [ADDR_W:0]     cfg_lines,
   output logic                busy,
   output logic                done,
   output logic                err_tlast,

   input  logic [DATA_W-1:0]   s_axis_tdata,
   input  logic                s_axis_tvalid,
   input  logic                s_axis_tlast,
   output logic                s_axis_tready,

   output logic [DATA_W-1:0]   m_axis_tdata,
   output logic                m_axis_tlast,
   output logic                m_axis_tvalid,
   input  logic                m_axis_tready,

   output logic                bram_en,
   output logic                bram_we,
   output logic [ADDR_W-1:0]   bram_addr,
   output logic [LINE_W-1:0]   bram_wdata,
   input  logic [LINE_W-1:0]   bram_rdata
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WR_FILL,
      S_WR_COMMIT,
      S_RD_REQ,
      S_RD_WAIT,
      S_RD_DRAIN,
      S_DONE
   } state_t;

   localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(WORDS_PER_LINE - 1);
   localparam logic [1:0]       WAIT_LAST = 2'(RD_LAT - 1);
   localparam logic [ADDR_W:0]  LINE_ONE  = (ADDR_W + 1)'(1);

   state_t             state;
   state_t             state_nxt;

   logic [DATA_W-1:0]  line_buf [WORDS_PER_LINE];
   logic [PTR_W-1:0]   ptr;
   logic [ADDR_W:0]    line_idx;
   logic [ADDR_W:0]    lines_q;
   logic [ADDR_W-1:0]  base_q;
   logic [1:0]         wait_cnt;
   logic               early_q;
   logic               err_q;

   logic               ptr_at_end;
   logic               last_line;

   assign ptr_at_end = (ptr == PTR_LAST);
   // line_idx counts completed lines, so the line in flight is the last one
   // when one more completion would reach the commanded count.
   assign last_line  = ((line_idx + LINE_ONE) == lines_q);

   // Truncation to ADDR_W bits gives the silent wrap of the line address.
   assign bram_addr  = base_q + line_idx[ADDR_W-1:0];
   assign err_tlast  = err_q;

   // Word k of the line sits at bits [k*DATA_W +: DATA_W]; word 0 is the first beat.
   always_comb begin
      bram_wdata = '0;
      for (int k = 0; k < WORDS_PER_LINE; k++) begin
         bram_wdata[k*DATA_W +: DATA_W] = line_buf[k];
      end
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      busy          = (state != S_IDLE);
      done          = 1'b0;
      s_axis_tready = 1'b0;
      m_axis_tvalid = 1'b0;
      m_axis_tlast  = 1'b0;
      m_axis_tdata  = '0;
      bram_en       = 1'b0;
      bram_we       = 1'b0;

      case (state)
         S_IDLE: begin
            if (cfg_start) begin
               if (cfg_lines == '0) begin
                  state_nxt = S_DONE;
               end else if (cfg_mode) begin
                  state_nxt = S_RD_REQ;
               end else begin
                  state_nxt = S_WR_FILL;
               end
            end
         end

         S_WR_FILL: begin
            s_axis_tready = 1'b1;
            // An early tlast still commits the partial (zero-padded) line.
            if (s_axis_tvalid && (ptr_at_end || s_axis_tlast)) begin
               state_nxt = S_WR_COMMIT;
            end
         end

         S_WR_COMMIT: begin
            bram_en = 1'b1;
            bram_we = 1'b1;
            state_nxt = (last_line || early_q) ? S_DONE : S_WR_FILL;
         end

         S_RD_REQ: begin
            bram_en   = 1'b1;
            state_nxt = S_RD_WAIT;
         end

         S_RD_WAIT: begin
            if (wait_cnt == WAIT_LAST) begin
               state_nxt = S_RD_DRAIN;
            end
         end

         S_RD_DRAIN: begin
            m_axis_tvalid = 1'b1;
            m_axis_tdata  = line_buf[ptr];
            m_axis_tlast  = ptr_at_end && last_line;
            if (m_axis_tready && ptr_at_end) begin
               state_nxt = last_line ? S_DONE : S_RD_REQ;
            end
         end

         S_DONE: begin
            done      = 1'b1;
            state_nxt = S_IDLE;
         end

         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         base_q   <= '0;
         lines_q  <= '0;
         line_idx <= '0;
         ptr      <= '0;
         wait_cnt <= '0;
         early_q  <= 1'b0;
         err_q    <= 1'b0;
         for (int k = 0; k < WORDS_PER_LINE; k++) begin
            line_buf[k] <= '0;
         end
      end else begin
         case (state)
            S_IDLE: begin
               if (cfg_start) begin
                  base_q   <= cfg_base;
                  lines_q  <= cfg_lines;
                  line_idx <= '0;
                  ptr      <= '0;
                  early_q  <= 1'b0;
                  err_q    <= 1'b0;
                  for (int k = 0; k < WORDS_PER_LINE; k++) begin
                     line_buf[k] <= '0;
                  end
               end
            end

            S_WR_FILL: begin
               if (s_axis_tvalid) begin
                  line_buf[ptr] <= s_axis_tdata;
                  ptr           <= ptr + 1'b1;
                  if (s_axis_tlast && !ptr_at_end) begin
                     err_q   <= 1'b1;
                     early_q <= 1'b1;
                  end
                  // Missing tlast on the final beat is flagged but does not cut the command short.
                  if (ptr_at_end && last_line && !s_axis_tlast) begin
                     err_q <= 1'b1;
                  end
               end
            end

            S_WR_COMMIT: begin
               ptr      <= '0;
               line_idx <= line_idx + 1'b1;
               for (int k = 0; k < WORDS_PER_LINE; k++) begin
                  line_buf[k] <= '0;
               end
            end

            S_RD_REQ: begin
               wait_cnt <= '0;
            end

            S_RD_WAIT: begin
               if (wait_cnt == WAIT_LAST) begin
                  ptr <= '0;
                  for (int k = 0; k < WORDS_PER_LINE; k++) begin
                     line_buf[k] <= bram_rdata[k*DATA_W +: DATA_W];
                  end
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end

            S_RD_DRAIN: begin
               if (m_axis_tready) begin
                  if (ptr_at_end) begin
                     ptr      <= '0;
                     line_idx <= line_idx + 1'b1;
                  end else begin
                     ptr <= ptr + 1'b1;
                  end
               end
            end

            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_axis_bram_burst_adapter.sv
// tb/tb_axis_bram_burst_adapter.sv - directed bench for axis_bram_burst_adapter
//
// Two instances share one clock: u_dut_a (WPL=4, ADDR_W=12, RD_LAT=1) and
// u_dut_b (WPL=4, ADDR_W=4, RD_LAT=3). sel routes the command strobe and the
// observed status/stream outputs to one instance. Cycle 0 is the cycle in
// which cfg_start is driven; outputs are sampled on the falling edge.

module tb_axis_bram_burst_adapter;

   localparam int LW = 128;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        areset;
   logic        mem_init;
   logic        sel;
   logic        cfg_start;
   logic        cfg_mode;
   logic [11:0] cfg_base;
   logic [12:0] cfg_lines;
   logic [31:0] s_tdata;
   logic        s_tvalid;
   logic        s_tlast;
   logic        m_tready;

   logic        start_a, start_b;
   assign start_a = cfg_start & ~sel;
   assign start_b = cfg_start & sel;

   logic          busy_a, done_a, err_a, s_tready_a, m_tlast_a, m_tvalid_a, en_a, we_a;
   logic [31:0]   m_tdata_a;
   logic [11:0]   addr_a;
   logic [LW-1:0] wdata_a, rdata_a;

   logic          busy_b, done_b, err_b, s_tready_b, m_tlast_b, m_tvalid_b, en_b, we_b;
   logic [31:0]   m_tdata_b;
   logic [3:0]    addr_b;
   logic [LW-1:0] wdata_b, rdata_b;

   logic          busy, done, err, s_tready, m_tlast, m_tvalid;
   logic [31:0]   m_tdata;
   assign busy     = sel ? busy_b     : busy_a;
   assign done     = sel ? done_b     : done_a;
   assign err      = sel ? err_b      : err_a;
   assign s_tready = sel ? s_tready_b : s_tready_a;
   assign m_tlast  = sel ? m_tlast_b  : m_tlast_a;
   assign m_tvalid = sel ? m_tvalid_b : m_tvalid_a;
   assign m_tdata  = sel ? m_tdata_b  : m_tdata_a;

   axis_bram_burst_adapter #(
      .DATA_W(32), .WORDS_PER_LINE(4), .ADDR_W(12), .RD_LAT(1)
   ) u_dut_a (
      .aclk(clk), .areset(areset),
      .cfg_start(start_a), .cfg_mode(cfg_mode), .cfg_base(cfg_base), .cfg_lines(cfg_lines),
      .busy(busy_a), .done(done_a), .err_tlast(err_a),
      .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
      .s_axis_tready(s_tready_a),
      .m_axis_tdata(m_tdata_a), .m_axis_tlast(m_tlast_a), .m_axis_tvalid(m_tvalid_a),
      .m_axis_tready(m_tready),
      .bram_en(en_a), .bram_we(we_a), .bram_addr(addr_a),
      .bram_wdata(wdata_a), .bram_rdata(rdata_a)
   );

   axis_bram_burst_adapter #(
      .DATA_W(32), .WORDS_PER_LINE(4), .ADDR_W(4), .RD_LAT(3)
   ) u_dut_b (
      .aclk(clk), .areset(areset),
      .cfg_start(start_b), .cfg_mode(cfg_mode), .cfg_base(cfg_base[3:0]), .cfg_lines(cfg_lines[4:0]),
      .busy(busy_b), .done(done_b), .err_tlast(err_b),
      .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
      .s_axis_tready(s_tready_b),
      .m_axis_tdata(m_tdata_b), .m_axis_tlast(m_tlast_b), .m_axis_tvalid(m_tvalid_b),
      .m_axis_tready(m_tready),
      .bram_en(en_b), .bram_we(we_b), .bram_addr(addr_b),
      .bram_wdata(wdata_b), .bram_rdata(rdata_b)
   );

   function automatic logic [LW-1:0] line_b(input int l);
      logic [LW-1:0] v;
      for (int k = 0; k < 4; k++) v[k*32 +: 32] = 32'hB000_0000 + 32'(l * 16 + k);
      return v;
   endfunction

   function automatic logic [31:0] exp_beat(input logic s, input int j);
      if (s) return 32'hB000_0000 + 32'((j / 4) * 16 + (j % 4));
      return 32'(j + 1);
   endfunction

   // BRAM A: latency 1
   logic [LW-1:0] mem_a [4096];
   int wr_cnt_a = 0;
   int en_cnt_a = 0;
   always @(posedge clk) begin
      if (mem_init) begin
         for (int k = 0; k < 4096; k++) mem_a[k] <= '0;
      end else if (en_a && we_a) begin
         mem_a[addr_a] <= wdata_a;
      end
      if (en_a && !we_a) rdata_a <= mem_a[addr_a];
      if (en_a) en_cnt_a <= en_cnt_a + 1;
      if (en_a && we_a) wr_cnt_a <= wr_cnt_a + 1;
   end

   // BRAM B: latency 3, preloaded at 0xF and 0x0, read addresses logged
   logic [LW-1:0] mem_b [16];
   logic [LW-1:0] rd_pipe_b [3];
   logic [3:0]    rd_addr_b [16];
   logic [3:0]    rd_n_b = 4'd0;
   assign rdata_b = rd_pipe_b[2];
   always @(posedge clk) begin
      if (mem_init) begin
         for (int k = 0; k < 16; k++) mem_b[k] <= '0;
         mem_b[15] <= line_b(0);
         mem_b[0]  <= line_b(1);
      end else if (en_b && we_b) begin
         mem_b[addr_b] <= wdata_b;
      end
      if (en_b && !we_b) rd_pipe_b[0] <= mem_b[addr_b];
      rd_pipe_b[1] <= rd_pipe_b[0];
      rd_pipe_b[2] <= rd_pipe_b[1];
      if (en_b && !we_b && rd_n_b != 4'd15) begin
         rd_addr_b[rd_n_b] <= addr_b;
         rd_n_b <= rd_n_b + 4'd1;
      end
   end

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic run_write(input logic [11:0] base, input logic [12:0] lines, input int n_beats,
                            input int tlast_idx, input logic [31:0] tag, input int poke_cyc,
                            output int done_cyc, output logic err_at_done);
      int i;
      i = 0;
      done_cyc = -1;
      err_at_done = 1'b0;
      sel = 1'b0;
      @(negedge clk);
      cfg_mode = 1'b0; cfg_base = base; cfg_lines = lines; cfg_start = 1'b1;
      s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0;
      for (int c = 1; c < 100 && done_cyc < 0; c++) begin
         @(negedge clk);
         cfg_start = (c == poke_cyc);
         if (c == poke_cyc) begin
            cfg_mode = 1'b1; cfg_base = 12'h300; cfg_lines = 13'd7;
         end
         if (done) begin
            done_cyc = c;
            err_at_done = err;
         end
         s_tvalid = (i < n_beats);
         s_tdata  = tag + 32'(i + 1);
         s_tlast  = (i == tlast_idx);
         if (s_tvalid && s_tready) i++;
      end
      cfg_start = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0;
      chk("wr_timeout", LW'(done_cyc >= 0), LW'(1));
      @(negedge clk);
      chk("wr_done_pulse", LW'(done), LW'(0));
      chk("wr_busy_after", LW'(busy), LW'(0));
   endtask

   task automatic run_read(input logic s, input logic [11:0] base, input logic [12:0] lines,
                           input int stall_pct, output int first_cyc, output int last_cyc,
                           output int done_cyc);
      int j, nb;
      logic hold, ht;
      logic [31:0] hd;
      j = 0; nb = 4 * int'(lines);
      hold = 1'b0; ht = 1'b0; hd = '0;
      first_cyc = -1; last_cyc = -1; done_cyc = -1;
      sel = s;
      @(negedge clk);
      cfg_mode = 1'b1; cfg_base = base; cfg_lines = lines; cfg_start = 1'b1; m_tready = 1'b0;
      for (int c = 1; c < 300 && done_cyc < 0; c++) begin
         @(negedge clk);
         cfg_start = 1'b0;
         if (hold) begin
            chk("hold_valid", LW'(m_tvalid), LW'(1));
            chk("hold_data", LW'(m_tdata), LW'(hd));
            chk("hold_last", LW'(m_tlast), LW'(ht));
         end
         if (done) done_cyc = c;
         m_tready = ($urandom_range(0, 99) >= stall_pct);
         if (m_tvalid && first_cyc < 0) first_cyc = c;
         if (m_tvalid && m_tready) begin
            chk("rd_data", LW'(m_tdata), LW'(exp_beat(s, j)));
            chk("rd_last", LW'(m_tlast), LW'(j == nb - 1));
            j++;
            last_cyc = c;
            hold = 1'b0;
         end else begin
            hold = m_tvalid; hd = m_tdata; ht = m_tlast;
         end
      end
      m_tready = 1'b0;
      chk("rd_timeout", LW'(done_cyc >= 0), LW'(1));
      chk("rd_beats", LW'(j), LW'(nb));
   endtask

   int   dc, fc, lc, w0, e0;
   logic e;

   initial begin
      areset = 1'b1; mem_init = 1'b1; sel = 1'b0;
      cfg_start = 1'b0; cfg_mode = 1'b0; cfg_base = '0; cfg_lines = '0;
      s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b0;
      repeat (3) @(negedge clk);
      mem_init = 1'b0;
      @(negedge clk);
      chk("rst_busy", LW'(busy_a), LW'(0));
      chk("rst_done", LW'(done_a), LW'(0));
      chk("rst_err", LW'(err_a), LW'(0));
      chk("rst_s_tready", LW'(s_tready_a), LW'(0));
      chk("rst_m_tvalid", LW'(m_tvalid_a), LW'(0));
      chk("rst_m_tlast", LW'(m_tlast_a), LW'(0));
      chk("rst_m_tdata", LW'(m_tdata_a), LW'(0));
      chk("rst_en_we", LW'({en_a, we_a, en_b, we_b}), LW'(0));
      chk("rst_addr", LW'(addr_a), LW'(0));
      chk("rst_wdata", wdata_a, LW'(0));
      chk("rst_busy_b", LW'(busy_b), LW'(0));
      areset = 1'b0;

      // two-line write, beats 1..8
      w0 = wr_cnt_a;
      run_write(12'h010, 13'd2, 8, 7, 32'h0, -1, dc, e);
      chk("w1_done_cyc", LW'(dc), LW'(11));
      chk("w1_err", LW'(e), LW'(0));
      chk("w1_line0", mem_a[12'h010], 128'h00000004_00000003_00000002_00000001);
      chk("w1_line1", mem_a[12'h011], 128'h00000008_00000007_00000006_00000005);
      chk("w1_commits", LW'(wr_cnt_a - w0), LW'(2));

      // read back with tready held high
      run_read(1'b0, 12'h010, 13'd2, 0, fc, lc, dc);
      chk("r1_first_valid", LW'(fc), LW'(3));
      chk("r1_last_beat", LW'(lc), LW'(12));
      chk("r1_done_cyc", LW'(dc), LW'(13));

      // three-line write cut short by tlast on beat 6
      w0 = wr_cnt_a;
      run_write(12'h040, 13'd3, 6, 5, 32'h200, -1, dc, e);
      chk("w3_done_cyc", LW'(dc), LW'(9));
      chk("w3_err", LW'(e), LW'(1));
      chk("w3_err_sticky", LW'(err_a), LW'(1));
      chk("w3_line0", mem_a[12'h040], 128'h00000204_00000203_00000202_00000201);
      chk("w3_line1", mem_a[12'h041], 128'h00000000_00000000_00000206_00000205);
      chk("w3_line2", mem_a[12'h042], LW'(0));
      chk("w3_commits", LW'(wr_cnt_a - w0), LW'(2));

      // empty command: immediate done, no BRAM access, error cleared
      e0 = en_cnt_a;
      run_write(12'h060, 13'd0, 0, -1, 32'h0, -1, dc, e);
      chk("w0_done_cyc", LW'(dc), LW'(1));
      chk("w0_err_cleared", LW'(e), LW'(0));
      chk("w0_no_access", LW'(en_cnt_a - e0), LW'(0));

      // final beat without tlast: flagged, completes normally
      run_write(12'h050, 13'd1, 4, -1, 32'h300, -1, dc, e);
      chk("wn_done_cyc", LW'(dc), LW'(6));
      chk("wn_err", LW'(e), LW'(1));
      chk("wn_line0", mem_a[12'h050], 128'h00000304_00000303_00000302_00000301);

      // cfg_start pulsed while busy is ignored
      e0 = en_cnt_a;
      run_write(12'h020, 13'd1, 4, 3, 32'h100, 2, dc, e);
      chk("wp_done_cyc", LW'(dc), LW'(6));
      chk("wp_err", LW'(e), LW'(0));
      chk("wp_line0", mem_a[12'h020], 128'h00000104_00000103_00000102_00000101);
      chk("wp_accesses", LW'(en_cnt_a - e0), LW'(1));

      // wrap across address 0xF -> 0x0 with RD_LAT=3 and random stalls
      run_read(1'b1, 12'h00F, 13'd2, 30, fc, lc, dc);
      chk("rb_first_valid", LW'(fc), LW'(5));
      chk("rb_reads", LW'(rd_n_b), LW'(2));
      chk("rb_addr0", LW'(rd_addr_b[0]), LW'(4'hF));
      chk("rb_addr1", LW'(rd_addr_b[1]), LW'(4'h0));

      // reset in the middle of RD_DRAIN
      sel = 1'b0;
      @(negedge clk);
      cfg_mode = 1'b1; cfg_base = 12'h010; cfg_lines = 13'd2; cfg_start = 1'b1; m_tready = 1'b0;
      repeat (4) begin
         @(negedge clk);
         cfg_start = 1'b0;
      end
      chk("rd_rst_pre_valid", LW'(m_tvalid), LW'(1));
      areset = 1'b1;
      @(negedge clk);
      chk("rd_rst_valid", LW'(m_tvalid), LW'(0));
      chk("rd_rst_busy", LW'(busy), LW'(0));
      chk("rd_rst_tdata", LW'(m_tdata), LW'(0));
      areset = 1'b0;
      run_read(1'b0, 12'h010, 13'd2, 0, fc, lc, dc);
      chk("rr_first_valid", LW'(fc), LW'(3));
      chk("rr_done_cyc", LW'(dc), LW'(13));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
